// File: rtl/pio_arbiter.sv
// Round-robin arbiter sharing one registered-read GPIO slave between two Avalon-MM requesters.
// One transaction runs on the GPIO side at a time; each requester is released with a one-cycle ACK.
module pio_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic                  csi_MCLK_clk,
    input  logic                  rsi_MRST_reset,
    input  logic [ADDR_W-1:0]     avs_s0_address,
    input  logic [DATA_W-1:0]     avs_s0_writedata,
    input  logic [DATA_W/8-1:0]   avs_s0_byteenable,
    input  logic                  avs_s0_write,
    input  logic                  avs_s0_read,
    output logic [DATA_W-1:0]     avs_s0_readdata,
    output logic                  avs_s0_waitrequest,
    input  logic [ADDR_W-1:0]     avs_s1_address,
    input  logic [DATA_W-1:0]     avs_s1_writedata,
    input  logic [DATA_W/8-1:0]   avs_s1_byteenable,
    input  logic                  avs_s1_write,
    input  logic                  avs_s1_read,
    output logic [DATA_W-1:0]     avs_s1_readdata,
    output logic                  avs_s1_waitrequest,
    output logic [ADDR_W-1:0]     avm_gpio_address,
    output logic [DATA_W-1:0]     avm_gpio_writedata,
    output logic [DATA_W/8-1:0]   avm_gpio_byteenable,
    output logic                  avm_gpio_write,
    output logic                  avm_gpio_read,
    input  logic [DATA_W-1:0]     avm_gpio_readdata
);

    typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_CAP, ACK} state_t;

    state_t                r_state;
    logic                  r_last_grant;
    logic                  r_port;
    logic                  r_write;
    logic                  r_read;
    logic                  r_wait0;
    logic                  r_wait1;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_be;
    logic [DATA_W-1:0]     r_rdata0;
    logic [DATA_W-1:0]     r_rdata1;

    logic                  w_req0;
    logic                  w_req1;
    logic                  w_pick1;
    logic                  w_sel_wr;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [DATA_W-1:0]     w_sel_wdata;
    logic [DATA_W/8-1:0]   w_sel_be;

    assign w_req0      = avs_s0_write | avs_s0_read;
    assign w_req1      = avs_s1_write | avs_s1_read;
    // On a tie, s1 wins only if s0 was served last.
    assign w_pick1     = w_req1 & (~w_req0 | ~r_last_grant);
    assign w_sel_wr    = w_pick1 ? avs_s1_write      : avs_s0_write;
    assign w_sel_addr  = w_pick1 ? avs_s1_address    : avs_s0_address;
    assign w_sel_wdata = w_pick1 ? avs_s1_writedata  : avs_s0_writedata;
    assign w_sel_be    = w_pick1 ? avs_s1_byteenable : avs_s0_byteenable;

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_write      <= 1'b0;
            r_read       <= 1'b0;
            r_wait0      <= 1'b1;
            r_wait1      <= 1'b1;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req0 || w_req1) begin
                        r_port       <= w_pick1;
                        r_last_grant <= w_pick1;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_be         <= w_sel_be;
                        r_write      <= w_sel_wr;
                        r_read       <= ~w_sel_wr;
                        r_state      <= w_sel_wr ? WR : RD_ADDR;
                    end
                end
                WR: begin
                    r_write <= 1'b0;
                    r_state <= ACK;
                    if (r_port) begin
                        r_wait1  <= 1'b0;
                        r_rdata1 <= '0;
                    end else begin
                        r_wait0  <= 1'b0;
                        r_rdata0 <= '0;
                    end
                end
                RD_ADDR: begin
                    r_read  <= 1'b0;
                    r_state <= RD_CAP;
                end
                RD_CAP: begin
                    // Slave data is valid now; the per-port readdata register is the hold register.
                    r_state <= ACK;
                    if (r_port) begin
                        r_wait1  <= 1'b0;
                        r_rdata1 <= avm_gpio_readdata;
                    end else begin
                        r_wait0  <= 1'b0;
                        r_rdata0 <= avm_gpio_readdata;
                    end
                end
                ACK: begin
                    r_wait0 <= 1'b1;
                    r_wait1 <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign avm_gpio_address    = r_addr;
    assign avm_gpio_writedata  = r_wdata;
    assign avm_gpio_byteenable = r_be;
    assign avm_gpio_write      = r_write;
    assign avm_gpio_read       = r_read;
    assign avs_s0_waitrequest  = r_wait0;
    assign avs_s1_waitrequest  = r_wait1;
    assign avs_s0_readdata     = r_rdata0;
    assign avs_s1_readdata     = r_rdata1;

endmodule

// File: tb/tb_pio_arbiter.sv
// Bench for pio_arbiter: GPIO slave model, transaction-level reference model checked every cycle,
// and directed scenarios with hand-computed cycle/data expectations.
module tb_pio_arbiter;

    localparam int AW = 3;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] s0_addr = '0, s1_addr = '0;
    logic [DW-1:0] s0_wdata = '0, s1_wdata = '0;
    logic [BW-1:0] s0_be = '0, s1_be = '0;
    logic          s0_wr = 1'b0, s0_rd = 1'b0, s1_wr = 1'b0, s1_rd = 1'b0;
    logic [DW-1:0] s0_rdata, s1_rdata;
    logic          s0_wait, s1_wait;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic [BW-1:0] g_be;
    logic          g_wr, g_rd;
    logic [DW-1:0] g_rdata = '0;

    pio_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .csi_MCLK_clk(clk), .rsi_MRST_reset(rst),
        .avs_s0_address(s0_addr), .avs_s0_writedata(s0_wdata), .avs_s0_byteenable(s0_be),
        .avs_s0_write(s0_wr), .avs_s0_read(s0_rd), .avs_s0_readdata(s0_rdata),
        .avs_s0_waitrequest(s0_wait),
        .avs_s1_address(s1_addr), .avs_s1_writedata(s1_wdata), .avs_s1_byteenable(s1_be),
        .avs_s1_write(s1_wr), .avs_s1_read(s1_rd), .avs_s1_readdata(s1_rdata),
        .avs_s1_waitrequest(s1_wait),
        .avm_gpio_address(g_addr), .avm_gpio_writedata(g_wdata), .avm_gpio_byteenable(g_be),
        .avm_gpio_write(g_wr), .avm_gpio_read(g_rd), .avm_gpio_readdata(g_rdata)
    );

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [DW-1:0] wd,
                                          input logic [BW-1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = wd[7:0];
        if (be[1]) r[15:8] = wd[15:8];
        return r;
    endfunction

    // 16-bit PIO slave: data at 2, output enable at 4, one-cycle registered read data.
    logic [15:0] sl_data = 16'hA5A5, sl_oe = 16'h0000;
    always @(posedge clk) begin
        if (g_wr && g_addr == 3'd2) sl_data <= merge(sl_data, g_wdata, g_be);
        if (g_wr && g_addr == 3'd4) sl_oe   <= merge(sl_oe, g_wdata, g_be);
        if (g_rd) g_rdata <= (g_addr == 3'd2) ? {16'h0, sl_data} :
                             (g_addr == 3'd4) ? {16'h0, sl_oe} : '0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_err = 0;
    task automatic chk32(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask
    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %b want %b", nm, cyc, act, exp);
        end
    endtask
    task automatic chki(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d want %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference model: a transaction occupies its grant cycle plus (len-1) further cycles;
    // phase counts cycles since grant, 0 meaning free to grant.
    logic          m_seen = 1'b0;
    logic [2:0]    m_ph = '0, m_len = 3'd3;
    logic          m_last = 1'b1, m_port = 1'b0, m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_val = '0, m_rq0 = '0, m_rq1 = '0;
    logic [BW-1:0] m_be = '0;
    logic [15:0]   m_g2 = 16'hA5A5, m_g4 = 16'h0000;

    wire           m_r0  = s0_wr | s0_rd;
    wire           m_r1  = s1_wr | s1_rd;
    wire           m_p   = (m_r0 && m_r1) ? ~m_last : m_r1;
    wire           m_w   = m_p ? s1_wr : s0_wr;
    wire [AW-1:0]  m_a   = m_p ? s1_addr : s0_addr;
    wire [DW-1:0]  m_d   = m_p ? s1_wdata : s0_wdata;
    wire [BW-1:0]  m_b   = m_p ? s1_be : s0_be;
    wire [2:0]     m_nph = (m_ph == m_len - 3'd1) ? 3'd0 : m_ph + 3'd1;

    always @(posedge clk) begin
        if (rst) begin
            m_seen <= 1'b1; m_ph <= '0; m_last <= 1'b1; m_port <= 1'b0; m_wr <= 1'b0;
            m_addr <= '0; m_wdata <= '0; m_be <= '0; m_rq0 <= '0; m_rq1 <= '0;
        end else if (m_seen) begin
            if (m_ph == 3'd0) begin
                if (m_r0 || m_r1) begin
                    m_port <= m_p; m_last <= m_p; m_wr <= m_w; m_len <= m_w ? 3'd3 : 3'd4;
                    m_ph <= 3'd1; m_addr <= m_a; m_wdata <= m_d; m_be <= m_b;
                    if (m_w && m_a == 3'd2) m_g2 <= merge(m_g2, m_d, m_b);
                    if (m_w && m_a == 3'd4) m_g4 <= merge(m_g4, m_d, m_b);
                    m_val <= (m_a == 3'd2) ? {16'h0, m_g2} : (m_a == 3'd4) ? {16'h0, m_g4} : '0;
                end
            end else begin
                m_ph <= m_nph;
                if (m_nph == m_len - 3'd1) begin
                    if (m_port) m_rq1 <= m_wr ? '0 : m_val;
                    else        m_rq0 <= m_wr ? '0 : m_val;
                end
            end
        end
    end

    wire e_ack  = (m_ph != 3'd0) && (m_ph == m_len - 3'd1);
    wire e_w0   = !(e_ack && !m_port);
    wire e_w1   = !(e_ack && m_port);
    wire e_gwr  = (m_ph == 3'd1) && m_wr;
    wire e_grd  = (m_ph == 3'd1) && !m_wr;

    int            wr_cyc[$], rd_cyc[$], ack_cyc[$], ack_port[$];
    logic [DW-1:0] wr_dat[$], ack_dat[$];
    logic [AW-1:0] wr_adr[$];

    always @(negedge clk) begin
        if (m_seen) begin
            chk1("s0_wait", s0_wait, e_w0);
            chk1("s1_wait", s1_wait, e_w1);
            chk1("gpio_write", g_wr, e_gwr);
            chk1("gpio_read", g_rd, e_grd);
            chk32("gpio_addr", 32'(g_addr), 32'(m_addr));
            chk32("gpio_wdata", g_wdata, m_wdata);
            chk32("gpio_be", 32'(g_be), 32'(m_be));
            chk32("s0_rdata", s0_rdata, m_rq0);
            chk32("s1_rdata", s1_rdata, m_rq1);
            if (g_wr) begin wr_cyc.push_back(cyc); wr_dat.push_back(g_wdata); wr_adr.push_back(g_addr); end
            if (g_rd) rd_cyc.push_back(cyc);
            if (!s0_wait) begin ack_cyc.push_back(cyc); ack_port.push_back(0); ack_dat.push_back(s0_rdata); end
            if (!s1_wait) begin ack_cyc.push_back(cyc); ack_port.push_back(1); ack_dat.push_back(s1_rdata); end
        end
    end

    task automatic clear_log();
        wr_cyc.delete(); rd_cyc.delete(); ack_cyc.delete(); ack_port.delete();
        wr_dat.delete(); ack_dat.delete(); wr_adr.delete();
    endtask

    // Drive one request and hold it until waitrequest drops (bounded).
    task automatic xact(input int port, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int budget);
        int   n;
        logic done;
        n = 0; done = 1'b0;
        if (port == 0) begin s0_wr = wr; s0_rd = ~wr; s0_addr = a; s0_wdata = d; s0_be = '1; end
        else           begin s1_wr = wr; s1_rd = ~wr; s1_addr = a; s1_wdata = d; s1_be = '1; end
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            if ((port == 0 ? s0_wait : s1_wait) == 1'b0) done = 1'b1;
        end
        chk1("xact_timeout", done, 1'b1);
    endtask

    task automatic release_port(input int port);
        if (port == 0) begin s0_wr = 1'b0; s0_rd = 1'b0; end
        else           begin s1_wr = 1'b0; s1_rd = 1'b0; end
    endtask

    task automatic gap();
        @(negedge clk);
        @(negedge clk);
        clear_log();
    endtask

    logic [DW-1:0] d0[3] = '{32'h0000_1111, 32'h0000_3333, 32'h0000_5555};
    logic [DW-1:0] d1[3] = '{32'h0000_2222, 32'h0000_4444, 32'h0000_6666};

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk1("rst_s0_wait", s0_wait, 1'b1);
        chk1("rst_s1_wait", s1_wait, 1'b1);
        chk32("rst_s0_rdata", s0_rdata, 32'h0);
        chk32("rst_s1_rdata", s1_rdata, 32'h0);
        chk1("rst_gwr", g_wr, 1'b0);
        chk1("rst_grd", g_rd, 1'b0);
        chk32("rst_gaddr", 32'(g_addr), 32'h0);
        rst = 1'b0;

        // Lone write from s0.
        gap(); t = cyc;
        xact(0, 1'b1, 3'd4, 32'h0000_FFFF, 20); release_port(0);
        @(negedge clk);
        chki("t1_nwr", wr_cyc.size(), 1);
        chki("t1_wr_cyc", wr_cyc[0], t + 1);
        chk32("t1_wr_addr", 32'(wr_adr[0]), 32'd4);
        chk32("t1_wr_data", wr_dat[0], 32'h0000_FFFF);
        chki("t1_nack", ack_cyc.size(), 1);
        chki("t1_ack_cyc", ack_cyc[0], t + 2);
        chki("t1_ack_port", ack_port[0], 0);

        // Lone read from s1.
        gap(); t = cyc;
        xact(1, 1'b0, 3'd2, '0, 20); release_port(1);
        @(negedge clk);
        chki("t2_rd_cyc", rd_cyc[0], t + 1);
        chki("t2_ack_cyc", ack_cyc[0], t + 3);
        chki("t2_ack_port", ack_port[0], 1);
        chk32("t2_rdata", ack_dat[0], 32'h0000_A5A5);

        // Continuous contention from reset.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; clear_log(); t = cyc;
        fork
            begin for (int i = 0; i < 3; i++) xact(0, 1'b1, 3'd2, d0[i], 40); release_port(0); end
            begin for (int j = 0; j < 3; j++) xact(1, 1'b1, 3'd2, d1[j], 40); release_port(1); end
        join
        @(negedge clk);
        chki("t3_nwr", wr_cyc.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chki("t3_wr_cyc", wr_cyc[k], t + 1 + 3 * k);
            chk32("t3_wr_data", wr_dat[k], (k % 2 == 0) ? d0[k / 2] : d1[k / 2]);
            chki("t3_ack_port", ack_port[k], k % 2);
        end

        // After an s0 write, simultaneous s0 write and s1 read: s1 goes first.
        gap();
        xact(0, 1'b1, 3'd4, 32'h0000_00C3, 20); release_port(0);
        @(negedge clk); clear_log(); t = cyc;
        fork
            begin xact(1, 1'b0, 3'd4, '0, 30); release_port(1); end
            begin xact(0, 1'b1, 3'd2, 32'h0000_7777, 30); release_port(0); end
        join
        @(negedge clk);
        chki("t4_rd_cyc", rd_cyc[0], t + 1);
        chki("t4_nwr", wr_cyc.size(), 1);
        chki("t4_wr_cyc", wr_cyc[0], t + 5);
        chki("t4_ack0_cyc", ack_cyc[0], t + 3);
        chki("t4_ack0_port", ack_port[0], 1);
        chk32("t4_rdata", ack_dat[0], 32'h0000_00C3);
        chki("t4_ack1_cyc", ack_cyc[1], t + 6);
        chki("t4_ack1_port", ack_port[1], 0);

        // Requester drops and scrambles its request right after grant.
        gap(); t = cyc;
        s0_wr = 1'b1; s0_addr = 3'd2; s0_wdata = 32'h0000_0F0F; s0_be = '1;
        @(negedge clk);
        s0_wr = 1'b0; s0_addr = 3'd4; s0_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        chki("t6_nwr", wr_cyc.size(), 1);
        chki("t6_wr_cyc", wr_cyc[0], t + 1);
        chk32("t6_wr_data", wr_dat[0], 32'h0000_0F0F);
        chk32("t6_wr_addr", 32'(wr_adr[0]), 32'd2);
        chki("t6_ack_cyc", ack_cyc[0], t + 2);
        chki("t6_ack_port", ack_port[0], 0);

        // Reset lands in RD_CAP: the read is abandoned.
        gap(); t = cyc;
        s1_rd = 1'b1; s1_addr = 3'd2; s1_be = '1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; s1_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk1("t5_s1_wait", s1_wait, 1'b1);
        chk1("t5_s0_wait", s0_wait, 1'b1);
        chk32("t5_s1_rdata", s1_rdata, 32'h0);
        chk1("t5_grd", g_rd, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chki("t5_nack", ack_cyc.size(), 0);
        chki("t5_nrd", rd_cyc.size(), 1);
        clear_log(); t = cyc;
        xact(1, 1'b0, 3'd2, '0, 20); release_port(1);
        @(negedge clk);
        chki("t5b_ack_cyc", ack_cyc[0], t + 3);
        chk32("t5b_rdata", ack_dat[0], 32'h0000_0F0F);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cycle %0d: got timeout want completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pio_arbiter.md
# pio_arbiter

Two-port Avalon-MM arbiter that shares a single GPIO register slave (16-bit PIO: data register at address 2, output-enable register at address 4, registered read data, waitrequest tied low) between two independent bus masters, e.g. a CPU and a hardware pattern engine. It serialises accesses with round-robin fairness and runs exactly one transaction on the GPIO side at a time. It handles the slave's one-cycle registered read latency and presents clean waitrequest handshakes to both requesters.

## Interface
Parameters:
- ADDR_W, 3, address width on all ports.
- DATA_W, 32, data width on all ports.

Ports:
- csi_MCLK_clk  in  1  system clock; all logic on its rising edge.
- rsi_MRST_reset  in  1  synchronous, active-high reset.
- avs_s0_address  in  ADDR_W  requester 0 address.
- avs_s0_writedata  in  DATA_W  requester 0 write data.
- avs_s0_byteenable  in  DATA_W/8  requester 0 byte enables.
- avs_s0_write / avs_s0_read  in  1  requester 0 strobes.
- avs_s0_readdata  out  DATA_W  requester 0 read data.
- avs_s0_waitrequest  out  1  requester 0 stall.
- avs_s1_*  (same set as s0)  requester 1.
- avm_gpio_address  out  ADDR_W  to GPIO slave.
- avm_gpio_writedata  out  DATA_W  to GPIO slave.
- avm_gpio_byteenable  out  DATA_W/8  to GPIO slave.
- avm_gpio_write / avm_gpio_read  out  1  to GPIO slave.
- avm_gpio_readdata  in  DATA_W  from GPIO slave; valid the cycle after address is presented.

## Operation
- FSM states: IDLE, WR, RD_ADDR, RD_CAP, ACK.
- IDLE: a port requests when its write or read is high. One requester: grant it. Both: grant the port not granted last (round-robin); after reset, last_grant = 1, so s0 wins the first tie.
- On grant, latch address, writedata, byteenable, direction and port number; update last_grant. Go to WR if write, else RD_ADDR. Write and read asserted together is treated as a write.
- WR: drive avm_gpio_write = 1 with latched address/data/byteenable for exactly one cycle, then go to ACK.
- RD_ADDR: drive avm_gpio_read = 1 and latched address for one cycle, then go to RD_CAP.
- RD_CAP: keep address driven with strobes low; register avm_gpio_readdata into the hold register; then go to ACK.
- ACK: granted port's waitrequest = 0 for exactly one cycle. Its readdata shows the hold register; this is don't-care for writes, which must drive 0. Next state is IDLE.
- avs_sN_waitrequest = 1 in every state except ACK for port N. The non-granted port always sees waitrequest = 1.
- avs_sN_readdata holds its value outside ACK; its reset value is 0.
- avm strobes are never asserted outside WR/RD_ADDR. avm address/data/byteenable equal the latched values; reset value is 0.
- A requester that deasserts or changes its request after grant has no effect; the latched transaction completes.

## Timing
- Cycle 0 = IDLE cycle with request visible.
- Write: avm_gpio_write high in cycle 1; waitrequest low in cycle 2. Requester holds its signals for 3 cycles.
- Read: avm_gpio_read high in cycle 1, slave data captured at end of cycle 2, waitrequest low with valid readdata in cycle 3.
- Back-to-back: IDLE follows ACK, so a pending request is granted in the cycle after ACK.
  - Write occupancy: 3 cycles per write.
  - Read occupancy: 4 cycles per read.
- Under continuous contention, grants strictly alternate s0, s1, s0, …
- Reset at any cycle: next state IDLE, strobes 0, both waitrequests 1, readdata 0, last_grant = 1. An in-flight transaction is abandoned and never acknowledged.

## Test plan
- s0 writes 0x0000FFFF to addr 4 alone -> avm_gpio_write high only in cycle 1 with addr 4 and data 0x0000FFFF; s0 waitrequest low only in cycle 2; s1 waitrequest stays 1.
- s1 reads addr 2 while the slave model returns 0x0000A5A5 one cycle after address -> avm_gpio_read high in cycle 1; s1 readdata = 0x0000A5A5 with waitrequest 0 in cycle 3.
- s0 and s1 both issue writes continuously from reset -> GPIO writes ordered s0, s1, s0, s1, each 3 cycles apart, with correct per-port data.
- s0 write and s1 read arrive in the same cycle after an s0 transaction -> s1 is granted first, then s0; no strobe overlap.
- Reset asserted in the RD_CAP cycle -> next cycle IDLE, no ACK emitted, readdata 0; a fresh request afterwards completes normally.
- s0 deasserts write the cycle after grant -> GPIO write still issued once with the latched data; ACK still occurs in cycle 2.
